// File: rtl/memtest_pkg.sv
// Shared types and constants for the SDRAM memory test engine.
// MEMTEST_BYTE_EN adds the byte-lane phase states to the FSM encoding.
package memtest_pkg;

   localparam int LFSR_W     = 16;
   localparam int ADR_W      = 21;
   localparam int GAP_CYCLES = 2;

   // Feedback mask for x^16+x^14+x^13+x^11+1 (bit n-1 holds tap n)
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [3:0] {
      IDLE,
      WAIT_RDY,
      WR_REQ,
      WR_GAP,
      RD_REQ,
      RD_GAP,
`ifdef MEMTEST_BYTE_EN
      BWR_REQ,
      BWR_GAP,
      BRD_REQ,
      BRD_GAP,
`endif
      DONE
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sdram_memtest_if.sv
// SDRAM request bus: the initiator drives stb/we/sel/adr/out, the bridge returns ack/dat.
interface sdram_memtest_if;
   import memtest_pkg::*;

   logic              stb;
   logic              we;
   logic [1:0]        sel;
   logic [ADR_W-1:0]  adr;
   logic [LFSR_W-1:0] out;
   logic [LFSR_W-1:0] dat;
   logic              ack;

   modport master (
      output stb, we, sel, adr, out,
      input  dat, ack
   );

   modport slave (
      input  stb, we, sel, adr, out,
      output dat, ack
   );

endinterface

// File: rtl/memtest_lfsr.sv
// 16-bit Fibonacci LFSR pattern source; load returns to SEED, advance steps once.
module memtest_lfsr
   import memtest_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= SEED;
      end else if (load) begin
         value <= SEED;
      end else if (advance) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/sdram_memtest.sv
// SDRAM BIST initiator: LFSR fill of a word range, read-back compare, first-failure capture.
// Define MEMTEST_BYTE_EN to append a high-byte-lane write/read phase after a passing word phase.
module sdram_memtest
   import memtest_pkg::*;
#(
   parameter logic [ADR_W-1:0]  START_ADR = 21'h000000,
   parameter logic [ADR_W-1:0]  END_ADR   = 21'h1FFFFF,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sdram_ready,
   sdram_memtest_if.master        sdram,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic                   timeout_err,
   output logic [ADR_W-1:0]       err_adr,
   output logic [LFSR_W-1:0]      err_exp,
   output logic [LFSR_W-1:0]      err_got
);

   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   // The REQ state's stb-raise cycle supplies the last low cycle of the gap
   localparam logic [1:0]  GAP_LAST = 2'(GAP_CYCLES - 2);

   state_t            state;
   state_t            gap_next;
   state_t            next_req;
   state_t            end_target;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] wr_data;
   logic [LFSR_W-1:0] exp_data;
   logic [1:0]        req_sel;
   logic [15:0]       tcnt;
   logic [1:0]        gap_cnt;
   logic              byte_ph;
   logic              is_req;
   logic              is_gap;
   logic              is_wr;
   logic              accept_start;
   logic              acked;
   logic              at_end;
   logic              gap_last;
   logic              mismatch;
   logic              lfsr_load;
   logic              lfsr_adv;

`ifdef MEMTEST_BYTE_EN
   assign byte_ph = state inside {BWR_REQ, BWR_GAP, BRD_REQ, BRD_GAP};
   assign is_req  = state inside {WR_REQ, RD_REQ, BWR_REQ, BRD_REQ};
   assign is_gap  = state inside {WR_GAP, RD_GAP, BWR_GAP, BRD_GAP};
   assign is_wr   = state inside {WR_REQ, BWR_REQ};
`else
   assign byte_ph = 1'b0;
   assign is_req  = state inside {WR_REQ, RD_REQ};
   assign is_gap  = state inside {WR_GAP, RD_GAP};
   assign is_wr   = (state == WR_REQ);
`endif

   assign accept_start = start && (state == IDLE || state == DONE);
   assign acked        = sdram.stb && sdram.ack && is_req;
   assign at_end       = (sdram.adr == END_ADR);
   assign gap_last     = is_gap && (gap_cnt == GAP_LAST);
   assign wr_data      = byte_ph ? {~lfsr[15:8], 8'h00} : lfsr;
   assign exp_data     = byte_ph ? {~lfsr[15:8], lfsr[7:0]} : lfsr;
   assign req_sel      = (byte_ph && is_wr) ? 2'b10 : 2'b11;
   assign mismatch     = !is_wr && (sdram.dat != exp_data);
   assign lfsr_load    = accept_start || (gap_last && at_end);
   assign lfsr_adv     = acked && !mismatch;

   always_comb begin
      gap_next   = WR_GAP;
      next_req   = WR_REQ;
      end_target = DONE;
      case (state)
         WR_REQ:  gap_next = WR_GAP;
         RD_REQ:  gap_next = RD_GAP;
         WR_GAP: begin
            next_req   = WR_REQ;
            end_target = RD_REQ;
         end
         RD_GAP: begin
            next_req   = RD_REQ;
`ifdef MEMTEST_BYTE_EN
            end_target = BWR_REQ;
`else
            end_target = DONE;
`endif
         end
`ifdef MEMTEST_BYTE_EN
         BWR_REQ: gap_next = BWR_GAP;
         BRD_REQ: gap_next = BRD_GAP;
         BWR_GAP: begin
            next_req   = BWR_REQ;
            end_target = BRD_REQ;
         end
         BRD_GAP: begin
            next_req   = BRD_REQ;
            end_target = DONE;
         end
`endif
         default: ;
      endcase
   end

   memtest_lfsr #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .value   (lfsr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sdram.stb   <= 1'b0;
         sdram.we    <= 1'b0;
         sdram.sel   <= 2'b11;
         sdram.adr   <= START_ADR;
         sdram.out   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout_err <= 1'b0;
         err_adr     <= '0;
         err_exp     <= '0;
         err_got     <= '0;
         tcnt        <= '0;
         gap_cnt     <= '0;
      end else if (accept_start) begin
         state       <= WAIT_RDY;
         busy        <= 1'b1;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout_err <= 1'b0;
         err_adr     <= '0;
         err_exp     <= '0;
         err_got     <= '0;
         sdram.adr   <= START_ADR;
      end else if (state == WAIT_RDY) begin
         if (sdram_ready) state <= WR_REQ;
      end else if (is_req) begin
         // A request is only launched while ready; once launched it runs to ack or timeout
         if (!sdram.stb) begin
            if (sdram_ready) begin
               sdram.stb <= 1'b1;
               sdram.we  <= is_wr;
               sdram.sel <= req_sel;
               if (is_wr) sdram.out <= wr_data;
               tcnt      <= '0;
            end
         end else if (sdram.ack) begin
            sdram.stb <= 1'b0;
            if (mismatch) begin
               err_adr <= sdram.adr;
               err_exp <= exp_data;
               err_got <= sdram.dat;
               busy    <= 1'b0;
               done    <= 1'b1;
               pass    <= 1'b0;
               state   <= DONE;
            end else begin
               gap_cnt <= '0;
               state   <= gap_next;
            end
         end else if (tcnt == TO_LAST) begin
            sdram.stb   <= 1'b0;
            timeout_err <= 1'b1;
            err_adr     <= sdram.adr;
            busy        <= 1'b0;
            done        <= 1'b1;
            pass        <= 1'b0;
            state       <= DONE;
         end else begin
            tcnt <= tcnt + 16'd1;
         end
      end else if (is_gap) begin
         if (!gap_last) begin
            gap_cnt <= gap_cnt + 2'd1;
         end else if (!at_end) begin
            sdram.adr <= sdram.adr + 21'd1;
            state     <= next_req;
         end else if (end_target == DONE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
            state <= DONE;
         end else begin
            sdram.adr <= START_ADR;
            state     <= end_target;
         end
      end
   end

endmodule

// File: tb/tb_sdram_memtest.sv
// Randomized bench for sdram_memtest: latency-3 responder, scoreboard of bus transfers and run results.
// Compile with MEMTEST_BYTE_EN to also model the byte-lane phase.
`timescale 1ns/1ps
module tb_sdram_memtest;
   import memtest_pkg::*;

   localparam logic [20:0] START_A  = 21'd0;
   localparam logic [20:0] END_A    = 21'd7;
   localparam logic [15:0] SEED_V   = 16'hACE1;
   localparam int          TMO      = 255;
   localparam int          RUN_MAX  = 6000;

   typedef struct {
      bit          we;
      logic [1:0]  sel;
      logic [20:0] adr;
      logic [15:0] data;
   } txn_t;

   typedef struct {
      bit          pass;
      bit          tmo;
      logic [20:0] adr;
      logic [15:0] exp;
      logic [15:0] got;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sdram_ready;
   logic        busy, done, pass, timeout_err;
   logic [20:0] err_adr;
   logic [15:0] err_exp, err_got;

   sdram_memtest_if bus ();

   int checks   = 0;
   int failures = 0;

   txn_t txn_q[$];
   res_t res_q[$];

   logic [15:0] mem [0:7];
   int          lat;
   bit          corrupt_en;
   logic [20:0] corrupt_adr;
   logic [15:0] corrupt_val;
   bit          noack_en;
   logic [20:0] noack_adr;
   bit          rand_ready;

   always #5 clk = ~clk;

   sdram_memtest #(
      .START_ADR (START_A),
      .END_ADR   (END_A),
      .SEED      (SEED_V),
      .TIMEOUT   (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .sdram_ready (sdram_ready),
      .sdram       (bus),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .timeout_err (timeout_err),
      .err_adr     (err_adr),
      .err_exp     (err_exp),
      .err_got     (err_got)
   );

   // Responder: ack combinational with stb on the third strobed cycle
   assign bus.ack = bus.stb && (lat == 2) && !(noack_en && bus.we && bus.adr == noack_adr);
   assign bus.dat = (corrupt_en && bus.adr == corrupt_adr) ? corrupt_val : mem[bus.adr[2:0]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat <= 0;
         for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
      end else begin
         if (bus.stb && !bus.ack) lat <= lat + 1;
         else                     lat <= 0;
         if (bus.stb && bus.ack && bus.we) begin
            if (bus.sel[1]) mem[bus.adr[2:0]][15:8] <= bus.out[15:8];
            if (bus.sel[0]) mem[bus.adr[2:0]][7:0]  <= bus.out[7:0];
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) sdram_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Reference LFSR step written from the polynomial x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] modelStep(input logic [15:0] v);
      int x;
      int fb;
      x  = int'(v);
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
      return 16'(((x << 1) | fb) & 32'hFFFF);
   endfunction

   task automatic buildExpected();
      logic [15:0] v;
      logic [15:0] want;
      logic [15:0] rd;
      res_t        r;
      r = '{pass: 1'b1, tmo: 1'b0, adr: '0, exp: '0, got: '0};
      v = SEED_V;
      for (int a = int'(START_A); a <= int'(END_A); a++) begin
         if (noack_en && a == int'(noack_adr)) begin
            r.pass = 1'b0; r.tmo = 1'b1; r.adr = 21'(a);
            res_q.push_back(r);
            return;
         end
         txn_q.push_back('{we: 1'b1, sel: 2'b11, adr: 21'(a), data: v});
         v = modelStep(v);
      end
      v = SEED_V;
      for (int a = int'(START_A); a <= int'(END_A); a++) begin
         txn_q.push_back('{we: 1'b0, sel: 2'b11, adr: 21'(a), data: 16'h0000});
         rd = (corrupt_en && a == int'(corrupt_adr)) ? corrupt_val : v;
         if (rd != v) begin
            r.pass = 1'b0; r.adr = 21'(a); r.exp = v; r.got = rd;
            res_q.push_back(r);
            return;
         end
         v = modelStep(v);
      end
`ifdef MEMTEST_BYTE_EN
      v = SEED_V;
      for (int a = int'(START_A); a <= int'(END_A); a++) begin
         txn_q.push_back('{we: 1'b1, sel: 2'b10, adr: 21'(a), data: {~v[15:8], 8'h00}});
         v = modelStep(v);
      end
      v = SEED_V;
      for (int a = int'(START_A); a <= int'(END_A); a++) begin
         want = {~v[15:8], v[7:0]};
         txn_q.push_back('{we: 1'b0, sel: 2'b11, adr: 21'(a), data: 16'h0000});
         rd = (corrupt_en && a == int'(corrupt_adr)) ? corrupt_val : want;
         if (rd != want) begin
            r.pass = 1'b0; r.adr = 21'(a); r.exp = want; r.got = rd;
            res_q.push_back(r);
            return;
         end
         v = modelStep(v);
      end
`endif
      res_q.push_back(r);
   endtask

   // Monitor: pops the scoreboard on every acked transfer and on every done rising edge
   initial begin
      bit   prev_stb;
      bit   prev_done;
      int   low_run;
      int   high_run;
      int   last_high;
      txn_t t;
      res_t r;
      prev_stb = 0; prev_done = 0; low_run = 0; high_run = 0; last_high = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            prev_stb = 0; prev_done = 0; low_run = 0; high_run = 0;
            continue;
         end
         if (bus.stb) begin
            if (!prev_stb) begin
               checkOutput("gap_low_cycles_ge2", 64'(low_run >= GAP_CYCLES), 64'd1);
               checkOutput("stb_while_done", 64'(done), 64'd0);
            end
            high_run++;
            low_run = 0;
            if (bus.ack) begin
               checkOutput("txn_expected_pending", 64'(txn_q.size() > 0), 64'd1);
               if (txn_q.size() > 0) begin
                  t = txn_q.pop_front();
                  checkOutput("txn_we", 64'(bus.we), 64'(t.we));
                  checkOutput("txn_sel", 64'(bus.sel), 64'(t.sel));
                  checkOutput("txn_adr", 64'(bus.adr), 64'(t.adr));
                  if (t.we) checkOutput("txn_wdata", 64'(bus.out), 64'(t.data));
               end
            end
         end else begin
            if (prev_stb) last_high = high_run;
            high_run = 0;
            low_run++;
         end
         if (done && !prev_done) begin
            checkOutput("result_expected_pending", 64'(res_q.size() > 0), 64'd1);
            if (res_q.size() > 0) begin
               r = res_q.pop_front();
               checkOutput("res_pass", 64'(pass), 64'(r.pass));
               checkOutput("res_timeout_err", 64'(timeout_err), 64'(r.tmo));
               checkOutput("res_err_adr", 64'(err_adr), 64'(r.adr));
               checkOutput("res_err_exp", 64'(err_exp), 64'(r.exp));
               checkOutput("res_err_got", 64'(err_got), 64'(r.got));
               checkOutput("res_busy_low", 64'(busy), 64'd0);
               if (r.tmo) checkOutput("timeout_stb_cycles", 64'(last_high), 64'(TMO));
            end
         end
         prev_stb  = bus.stb;
         prev_done = done;
      end
   end

   task automatic checkResetValues();
      checkOutput("rst_stb", 64'(bus.stb), 64'd0);
      checkOutput("rst_we", 64'(bus.we), 64'd0);
      checkOutput("rst_sel", 64'(bus.sel), 64'd3);
      checkOutput("rst_adr", 64'(bus.adr), 64'(START_A));
      checkOutput("rst_out", 64'(bus.out), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_pass", 64'(pass), 64'd0);
      checkOutput("rst_timeout_err", 64'(timeout_err), 64'd0);
      checkOutput("rst_err_adr", 64'(err_adr), 64'd0);
      checkOutput("rst_err_exp", 64'(err_exp), 64'd0);
      checkOutput("rst_err_got", 64'(err_got), 64'd0);
   endtask

   task automatic applyStimulus(input bit c_en, input logic [20:0] c_adr, input logic [15:0] c_val,
                                input bit n_en, input logic [20:0] n_adr, input bit rnd, input int hold);
      int stb_hits;
      bit finished;
      corrupt_en  = c_en;  corrupt_adr = c_adr; corrupt_val = c_val;
      noack_en    = n_en;  noack_adr   = n_adr;
      rand_ready  = 1'b0;
      sdram_ready = (hold == 0);
      buildExpected();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (hold > 0) begin
         stb_hits = 0;
         repeat (hold) begin
            @(negedge clk);
            if (bus.stb) stb_hits++;
         end
         checkOutput("no_stb_while_not_ready", 64'(stb_hits), 64'd0);
         @(posedge clk); #1 sdram_ready = 1'b1;
      end
      rand_ready = rnd;
      finished   = 1'b0;
      for (int c = 0; c < RUN_MAX; c++) begin
         @(posedge clk); #1;
         if (done) begin
            finished = 1'b1;
            break;
         end
      end
      rand_ready  = 1'b0;
      sdram_ready = 1'b1;
      checkOutput("run_finished", 64'(finished), 64'd1);
      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drained", 64'(txn_q.size() + res_q.size()), 64'd0);
      txn_q.delete();
      res_q.delete();
      if (!finished) begin
         @(negedge clk) rst_n = 1'b0;
         @(negedge clk) rst_n = 1'b1;
      end
      corrupt_en = 1'b0;
      noack_en   = 1'b0;
   endtask

   task automatic resetDuringRead();
      bit hit;
      corrupt_en = 1'b0; noack_en = 1'b0; rand_ready = 1'b0; sdram_ready = 1'b1;
      buildExpected();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < RUN_MAX; c++) begin
         @(negedge clk);
         if (bus.stb && !bus.we && bus.adr == 21'd3) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput("reached_read_adr3", 64'(hit), 64'd1);
      #2 rst_n = 1'b0;
      #1 checkResetValues();
      txn_q.delete();
      res_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL global_watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int kind;
      rst_n = 1'b0; start = 1'b0; sdram_ready = 1'b1; rand_ready = 1'b0;
      corrupt_en = 1'b0; corrupt_adr = '0; corrupt_val = '0;
      noack_en = 1'b0; noack_adr = '0;
      repeat (3) @(posedge clk);
      #1 checkResetValues();
      @(negedge clk) rst_n = 1'b1;

      $display("[TB] clean run");
      applyStimulus(1'b0, 21'd0, 16'h0000, 1'b0, 21'd0, 1'b0, 0);
      $display("[TB] corrupted read at adr 5");
      applyStimulus(1'b1, 21'd5, 16'h0000, 1'b0, 21'd0, 1'b0, 0);
      $display("[TB] missing ack on adr 2 write");
      applyStimulus(1'b0, 21'd0, 16'h0000, 1'b1, 21'd2, 1'b0, 0);
      $display("[TB] ready held low for 100 cycles");
      applyStimulus(1'b0, 21'd0, 16'h0000, 1'b0, 21'd0, 1'b0, 100);
      $display("[TB] reset during read of adr 3");
      resetDuringRead();
      applyStimulus(1'b0, 21'd0, 16'h0000, 1'b0, 21'd0, 1'b0, 0);

      for (int i = 0; i < 8; i++) begin
         kind = $urandom_range(0, 2);
         $display("[TB] random run %0d kind %0d", i, kind);
         case (kind)
            0: applyStimulus(1'b0, 21'd0, 16'h0000, 1'b0, 21'd0, 1'b1, 0);
            1: applyStimulus(1'b1, 21'($urandom_range(0, 7)), 16'($urandom), 1'b0, 21'd0, 1'b1, 0);
            default: applyStimulus(1'b0, 21'd0, 16'h0000, 1'b1, 21'($urandom_range(0, 7)), 1'b1, 0);
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
